// File: rtl/counter_step_decoder_if.sv
// Bus between an up/down/load counter's Qout and its step decoder.
// master = counter/stimulus side, slave = decoder side.
interface counter_step_decoder_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RUN_W = 4
);
    logic [WIDTH-1:0] q_in;
    logic             q_valid;
    logic             step_evt;
    logic             dir_up;
    logic             hold_evt;
    logic             wrap_evt;
    logic             jump_evt;
    logic [WIDTH-1:0] jump_value;
    logic [RUN_W-1:0] run_len;
    logic [7:0]       jump_cnt;

    modport master (
        output q_in, q_valid,
        input  step_evt, dir_up, hold_evt, wrap_evt, jump_evt,
        input  jump_value, run_len, jump_cnt
    );

    modport slave (
        input  q_in, q_valid,
        output step_evt, dir_up, hold_evt, wrap_evt, jump_evt,
        output jump_value, run_len, jump_cnt
    );
endinterface

// File: rtl/counter_step_decoder.sv
// Decodes a counter's value stream into step/hold/wrap/jump events with a run-length count.
// Optional COUNTER_DEC_JUMP_CNT_EN builds a saturating 8-bit jump counter (tied to 0 otherwise).
module counter_step_decoder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RUN_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    counter_step_decoder_if.slave  bus
);
    localparam int unsigned JCNT_W = 8;
    localparam logic [WIDTH-1:0] VAL_ONES = '1;
    localparam logic [WIDTH-1:0] VAL_ZERO = '0;
    localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;

    typedef enum logic {
        S_PRIME = 1'b0,
        S_TRACK = 1'b1
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_jump_value;
    logic [RUN_W-1:0] r_run_len;
    logic             r_step_evt;
    logic             r_dir_up;
    logic             r_hold_evt;
    logic             r_wrap_evt;
    logic             r_jump_evt;

    logic [WIDTH-1:0] w_delta;
    logic             w_is_up;
    logic             w_is_dn;
    logic             w_is_hold;
    logic             w_is_jump;
    logic             w_same_dir;
    logic [RUN_W-1:0] w_run_step;
    logic             w_jump_fire;

    // Modular delta classification against the previous sample
    assign w_delta     = bus.q_in - r_prev;
    assign w_is_up     = (w_delta == VAL_ONE);
    assign w_is_dn     = (w_delta == VAL_ONES);
    assign w_is_hold   = (w_delta == VAL_ZERO);
    assign w_is_jump   = !(w_is_up || w_is_dn || w_is_hold);
    assign w_jump_fire = bus.q_valid && (r_state == S_TRACK) && w_is_jump;

    // A run continues only if the new step matches the last direction and a run is in progress
    assign w_same_dir = (w_is_up == r_dir_up) && (r_run_len != '0);
    assign w_run_step = !w_same_dir            ? RUN_W'(1) :
                        (r_run_len == RUN_MAX) ? r_run_len :
                                                 r_run_len + RUN_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_PRIME;
            r_prev       <= '0;
            r_jump_value <= '0;
            r_run_len    <= '0;
            r_step_evt   <= 1'b0;
            r_dir_up     <= 1'b0;
            r_hold_evt   <= 1'b0;
            r_wrap_evt   <= 1'b0;
            r_jump_evt   <= 1'b0;
        end else begin
            r_step_evt <= 1'b0;
            r_hold_evt <= 1'b0;
            r_wrap_evt <= 1'b0;
            r_jump_evt <= 1'b0;
            if (!bus.q_valid) begin
                r_state   <= S_PRIME;
                r_run_len <= '0;
            end else begin
                case (r_state)
                    S_PRIME: begin
                        r_prev  <= bus.q_in;
                        r_state <= S_TRACK;
                    end
                    S_TRACK: begin
                        r_prev <= bus.q_in;
                        if (w_is_up) begin
                            r_step_evt <= 1'b1;
                            r_dir_up   <= 1'b1;
                            r_wrap_evt <= (r_prev == VAL_ONES);
                            r_run_len  <= w_run_step;
                        end else if (w_is_dn) begin
                            r_step_evt <= 1'b1;
                            r_dir_up   <= 1'b0;
                            r_wrap_evt <= (r_prev == VAL_ZERO);
                            r_run_len  <= w_run_step;
                        end else if (w_is_hold) begin
                            r_hold_evt <= 1'b1;
                        end else begin
                            r_jump_evt   <= 1'b1;
                            r_jump_value <= bus.q_in;
                            r_run_len    <= '0;
                        end
                    end
                    default: r_state <= S_PRIME;
                endcase
            end
        end
    end

    assign bus.step_evt   = r_step_evt;
    assign bus.dir_up     = r_dir_up;
    assign bus.hold_evt   = r_hold_evt;
    assign bus.wrap_evt   = r_wrap_evt;
    assign bus.jump_evt   = r_jump_evt;
    assign bus.jump_value = r_jump_value;
    assign bus.run_len    = r_run_len;

`ifdef COUNTER_DEC_JUMP_CNT_EN
    logic [JCNT_W-1:0] r_jump_cnt;

    // Saturating jump counter; only reset clears it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_jump_cnt <= '0;
        end else if (w_jump_fire && (r_jump_cnt != '1)) begin
            r_jump_cnt <= r_jump_cnt + JCNT_W'(1);
        end
    end

    assign bus.jump_cnt = r_jump_cnt;
`else
    logic w_unused;
    assign w_unused     = w_jump_fire;
    assign bus.jump_cnt = JCNT_W'(0);
`endif
endmodule

// File: doc/counter_step_decoder.md
Name: counter_step_decoder

Overview:
- Observer and decoder for the output bus of a synchronous up/down/load counter. Per valid sample it reports whether the counter stepped up, stepped down, held, wrapped, or jumped (load or reset).
- Sits next to the counter, on the far end of its Qout bus. Used by the integration bench and by on-chip monitors to recover the command stream from the count sequence.

Parameters:
- WIDTH, 4, width of the observed counter value; legal range is WIDTH >= 2.
- RUN_W, 4, width of the run-length counter for consecutive same-direction steps.

Ports:
- clk  input  1  rising-edge clock, same clock as the observed counter.
- reset_n  input  1  synchronous reset, active-low.
- q_in  input  WIDTH  observed counter value.
- q_valid  input  1  q_in is meaningful this cycle.
- step_evt  output  1  one-cycle pulse: the sample differed from the previous sample by exactly +1 or -1 (mod 2^WIDTH).
- dir_up  output  1  direction of the most recent step; 1 = up.
- hold_evt  output  1  one-cycle pulse: the sample equals the previous sample.
- wrap_evt  output  1  one-cycle pulse: up step from all-ones to 0, or down step from 0 to all-ones.
- jump_evt  output  1  one-cycle pulse: any other delta (load, reset or glitch).
- jump_value  output  WIDTH  q_in captured at the last jump_evt.
- run_len  output  RUN_W  count of consecutive same-direction steps; saturates at 2^RUN_W-1.
- jump_cnt  output  8  number of jumps seen; see Optional Feature.

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to PRIME.
  - All pulses = 0, dir_up = 0, jump_value = 0, run_len = 0, jump_cnt = 0, prev register = 0.
  - Reset asserted mid-run discards tracking. The first valid sample after release only primes.
- States: PRIME and TRACK.
- PRIME:
  - A cycle with q_valid=1 stores q_in into prev and moves to TRACK.
  - No event pulses. run_len and dir_up are unchanged.
- TRACK, cycle with q_valid=1:
  - Compute delta = q_in - prev, mod 2^WIDTH.
  - delta = 1: step_evt=1, dir_up=1.
  - delta = all-ones: step_evt=1, dir_up=0.
  - delta = 0: hold_evt=1. dir_up and run_len are unchanged.
  - Any other delta: jump_evt=1, jump_value=q_in, run_len=0. dir_up is unchanged.
  - wrap_evt asserts together with step_evt when prev = all-ones and delta = 1, or when prev = 0 and delta = all-ones.
  - run_len on a step: if the step has the same direction as the previous step and run_len > 0, increment with saturation. Otherwise set run_len = 1.
  - prev is loaded with q_in in every case.
- q_valid=0 in any state: return to PRIME, no pulses, run_len cleared to 0. The next valid sample only primes.
- Timing:
  - All outputs are registered.
  - Each pulse is high for exactly the one cycle following the clk edge that sampled the triggering q_in. Latency is 1 cycle.
  - At most one of step_evt, hold_evt and jump_evt is high in any cycle. wrap_evt implies step_evt.
- Arithmetic: all comparisons are modulo 2^WIDTH with no sign extension.

Optional Feature:
- Macro: COUNTER_DEC_JUMP_CNT_EN.
- Defined:
  - jump_cnt increments on every jump_evt cycle and saturates at 255.
  - jump_cnt clears only on reset_n.
- Undefined:
  - jump_cnt is tied to 0 and no counter register is built.
  - All other behaviour is identical.

Test Plan:
1. reset_n=0 for 2 cycles, then q_valid=1 with q_in=0 -> all pulses 0, dir_up=0, run_len=0 after priming. The first sample produces no event.
2. Feed 10,11,12,13,14,15 -> five step_evt pulses with dir_up=1, run_len=1,2,3,4,5, no wrap_evt. Then 0 -> step_evt=1, wrap_evt=1, run_len=6.
3. Feed 3,2,1,0,15 -> step_evt with dir_up=0. wrap_evt=1 on 0->15 only. run_len resets to 1 at the first down step after an up run.
4. Feed 5,5,12 -> hold_evt on the second 5 with run_len unchanged. Then jump_evt on 12 with jump_value=12 and run_len=0. jump_cnt=1 with COUNTER_DEC_JUMP_CNT_EN, 0 without.
5. Mid-run at run_len=3, drop q_valid for 1 cycle, then resume with 7,8 -> no event on 7 (primes), step_evt on 8 with run_len=1. Repeat with reset_n=0 for 1 cycle instead of the q_valid drop -> same response and all outputs cleared.
6. RUN_W=2: feed 20 consecutive up steps -> run_len saturates at 3 and holds while steps continue.
